micro_branch_mem_subsystem: RTL and testbench

- Combines three functions: microsequencer next-address decode, communication/processor port arbitration, and the 16-bit data RAM.
- Sits between the microstore/processor datapath and the external loader interface.
- The external loader owns the RAM whenever communication mode is active or the microprogram has signalled end.
- The microaddress register freezes while the loader owns the RAM.

---
 rtl/micro_branch_mem_subsystem.sv | 67 ++++++
 tb/tb_micro_branch_mem_subsystem.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/micro_branch_mem_subsystem.sv
// micro_branch_mem_subsystem: microsequencer next-address, loader/processor RAM port mux, 16-bit data RAM
module micro_branch_mem_subsystem #(
    parameter int ADDR_BITS = 8,
    parameter int UADDR_W   = 8
) (
    input  logic               i_clk1,
    input  logic               i_reset,
    input  logic               i_com_en_n,
    input  logic               i_halt,
    input  logic               i_jump_ir,
    input  logic               i_cond_z,
    input  logic               i_z,
    input  logic [UADDR_W-1:0] i_ir,
    input  logic [UADDR_W-1:0] i_next_field,
    output logic [UADDR_W-1:0] o_uaddr,
    input  logic               i_proc_write,
    input  logic [15:0]        i_proc_addr,
    input  logic [15:0]        i_proc_wdata,
    input  logic               i_com_write,
    input  logic [15:0]        i_com_addr,
    input  logic [15:0]        i_com_wdata,
    output logic               o_com_en,
    output logic [15:0]        o_mem_addr,
    output logic [15:0]        o_rdata,
    output logic               o_end_flag
);
    logic [15:0]          r_mem [0:(1<<ADDR_BITS)-1];
    logic [UADDR_W-1:0]   r_uaddr;
    logic                 r_end_flag;
    logic                 w_com_en;
    logic                 w_write;
    logic [15:0]          w_wdata;
    logic [ADDR_BITS-1:0] w_idx;

    // loader owns the RAM on request or once the microprogram has ended
    always_comb begin
        w_com_en   = ~i_com_en_n | i_halt;
        w_write    = w_com_en ? i_com_write : i_proc_write;
        w_wdata    = w_com_en ? i_com_wdata : i_proc_wdata;
        o_mem_addr = w_com_en ? i_com_addr  : i_proc_addr;
        w_idx      = o_mem_addr[ADDR_BITS-1:0];
    end

    // synchronous write port; contents survive reset
    always_ff @(posedge i_clk1) begin
        if (w_write) r_mem[w_idx] <= w_wdata;
    end

    // next microaddress: freeze while loader owns RAM, dispatch beats conditional branch
    always_ff @(posedge i_clk1) begin
        if (i_reset)
            r_uaddr <= '0;
        else if (!w_com_en)
            r_uaddr <= i_jump_ir ? i_ir : (i_cond_z && !i_z) ? r_uaddr + 1'b1 : i_next_field;
    end

    // end flag tracks halt every cycle regardless of RAM ownership
    always_ff @(posedge i_clk1) begin
        if (i_reset) r_end_flag <= 1'b0;
        else         r_end_flag <= i_halt;
    end

    assign o_rdata    = r_mem[w_idx];
    assign o_com_en   = w_com_en;
    assign o_uaddr    = r_uaddr;
    assign o_end_flag = r_end_flag;
endmodule

// File: tb/tb_micro_branch_mem_subsystem.sv
// tb_micro_branch_mem_subsystem: directed scoreboard bench for the microsequencer/RAM subsystem
module tb_micro_branch_mem_subsystem;
    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic        com_en_n = 1'b1;
    logic        halt = 1'b0;
    logic        jump_ir = 1'b0;
    logic        cond_z = 1'b0;
    logic        z = 1'b0;
    logic [7:0]  ir = '0;
    logic [7:0]  next_field = '0;
    logic [7:0]  uaddr;
    logic        proc_write = 1'b0;
    logic [15:0] proc_addr = '0;
    logic [15:0] proc_wdata = '0;
    logic        com_write = 1'b0;
    logic [15:0] com_addr = '0;
    logic [15:0] com_wdata = '0;
    logic        com_en;
    logic [15:0] mem_addr;
    logic [15:0] rdata;
    logic        end_flag;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    micro_branch_mem_subsystem dut (
        .i_clk1(clk1), .i_reset(reset), .i_com_en_n(com_en_n), .i_halt(halt),
        .i_jump_ir(jump_ir), .i_cond_z(cond_z), .i_z(z), .i_ir(ir),
        .i_next_field(next_field), .o_uaddr(uaddr), .i_proc_write(proc_write),
        .i_proc_addr(proc_addr), .i_proc_wdata(proc_wdata), .i_com_write(com_write),
        .i_com_addr(com_addr), .i_com_wdata(com_wdata), .o_com_en(com_en),
        .o_mem_addr(mem_addr), .o_rdata(rdata), .o_end_flag(end_flag)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [15:0] v);
        q.push_back('{tag, v});
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: got %h, no expectation queued", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                n_bad++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        // reset with loader idle
        next_field = 8'h05;
        push("rst_uaddr", 16'h0000); push("rst_end", 16'h0000); push("rst_com_en", 16'h0000);
        tick();
        check({8'h0, uaddr}); check({15'h0, end_flag}); check({15'h0, com_en});
        reset = 1'b0;
        push("next_05", 16'h0005); push("end_after_rst", 16'h0000);
        tick();
        check({8'h0, uaddr}); check({15'h0, end_flag});

        // dispatch beats conditional branch
        jump_ir = 1'b1; ir = 8'h3C; cond_z = 1'b1; z = 1'b1; next_field = 8'h10;
        push("dispatch_3c", 16'h003C);
        tick();
        check({8'h0, uaddr});
        ir = 8'hFF;
        push("dispatch_ff", 16'h00FF);
        tick();
        check({8'h0, uaddr});

        // conditional: not-taken wraps FF->00, taken loads next_field, not-taken increments
        jump_ir = 1'b0; cond_z = 1'b1; z = 1'b0;
        push("inc_wrap", 16'h0000);
        tick();
        check({8'h0, uaddr});
        z = 1'b1; next_field = 8'h22;
        push("cond_taken", 16'h0022);
        tick();
        check({8'h0, uaddr});
        z = 1'b0;
        push("inc_23", 16'h0023);
        tick();
        check({8'h0, uaddr});

        // loader write wins over a simultaneous processor write
        cond_z = 1'b0; next_field = 8'h77;
        com_en_n = 1'b0; com_write = 1'b1; com_addr = 16'h0104; com_wdata = 16'hBEEF;
        proc_write = 1'b1; proc_addr = 16'h0004; proc_wdata = 16'h1234;
        #1;
        push("ld_com_en", 16'h0001); push("ld_mem_addr", 16'h0104);
        check({15'h0, com_en}); check(mem_addr);
        push("ld_uaddr_hold", 16'h0023); push("ld_rdata", 16'hBEEF);
        tick();
        check({8'h0, uaddr}); check(rdata);
        com_en_n = 1'b1; com_write = 1'b0; proc_write = 1'b0; proc_addr = 16'h0004;
        #1;
        push("proc_com_en", 16'h0000); push("proc_mem_addr", 16'h0004); push("alias_rdata", 16'hBEEF);
        check({15'h0, com_en}); check(mem_addr); check(rdata);

        // halt forces loader ownership, blocks processor writes, freezes uaddr
        halt = 1'b1; proc_write = 1'b1; proc_wdata = 16'h1111; next_field = 8'h44;
        #1;
        push("halt_com_en", 16'h0001); push("halt_mem_addr", 16'h0104); push("halt_end_pre", 16'h0000);
        check({15'h0, com_en}); check(mem_addr); check({15'h0, end_flag});
        push("halt_end", 16'h0001); push("halt_uaddr", 16'h0023); push("halt_rdata", 16'hBEEF);
        tick();
        check({15'h0, end_flag}); check({8'h0, uaddr}); check(rdata);
        halt = 1'b0; proc_write = 1'b0;
        #1;
        push("unhalt_rdata", 16'hBEEF);
        check(rdata);
        push("unhalt_uaddr", 16'h0044); push("unhalt_end", 16'h0000);
        tick();
        check({8'h0, uaddr}); check({15'h0, end_flag});

        // processor write, then read-during-write through an aliased address
        proc_write = 1'b1; proc_addr = 16'h00A0; proc_wdata = 16'h5A5A;
        tick();
        proc_write = 1'b0;
        #1;
        push("pw_rdata", 16'h5A5A);
        check(rdata);
        proc_write = 1'b1; proc_addr = 16'h0204; proc_wdata = 16'h0F0F;
        #1;
        push("rdw_old", 16'hBEEF);
        check(rdata);
        push("rdw_new", 16'h0F0F);
        tick();
        check(rdata);
        proc_write = 1'b0;

        // reset leaves RAM alone and loader may write during reset
        reset = 1'b1; proc_addr = 16'h00A0;
        com_en_n = 1'b0; com_write = 1'b1; com_addr = 16'h0010; com_wdata = 16'h7777;
        push("rst_uaddr2", 16'h0000);
        tick();
        check({8'h0, uaddr});
        com_en_n = 1'b1; com_write = 1'b0;
        #1;
        push("rst_keep_a0", 16'h5A5A);
        check(rdata);
        proc_addr = 16'h0010;
        #1;
        push("rst_ld_write", 16'h7777);
        check(rdata);
        reset = 1'b0;

        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
